// File: rtl/sd_req_arbiter_pkg.sv
// Shared types and constants for the SD sector request arbiter.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package sd_req_arbiter_pkg;

   // Port ownership phases: free, request presented to SD, transfer in flight
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   localparam int REQ_FDC  = 0;
   localparam int REQ_ACSI = 1;

   localparam int LBA_W = 32;
   localparam int LEN_W = 16;

endpackage

// File: rtl/sd_req_arbiter_rr_pick.sv
// Round-robin requester picker with a sticky lock for the previous owner.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module sd_req_arbiter_rr_pick #(
   parameter int NREQ  = 2,
   parameter int IDX_W = 1
) (
   input  logic [NREQ-1:0]  pending,
   input  logic [IDX_W-1:0] last_owner,
   input  logic [NREQ-1:0]  lock,
   output logic             pick_vld,
   output logic [IDX_W-1:0] pick_idx
);

   logic [IDX_W-1:0] cand;

   // A locked, still-pending last owner keeps the port; otherwise scan onward from it with wrap
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      if (lock[last_owner] && pending[last_owner]) begin
         pick_vld = 1'b1;
         pick_idx = last_owner;
      end else begin
         for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(last_owner) + k) % NREQ);
            if (!pick_vld && pending[cand]) begin
               pick_vld = 1'b1;
               pick_idx = cand;
            end
         end
      end
   end

endmodule

// File: rtl/sd_req_arbiter.sv
// Shares the SD sector request port between requesters and routes busy/done/err back to the owner.
// Latency: one cycle from a pending request to sd_rd/sd_wr; every output is registered.
// Backpressure: requests are levels held until busy; no new grant until the port is back in IDLE.
module sd_req_arbiter
   import sd_req_arbiter_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int TO_W = 24,
   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2*NREQ-1:0]     rd_req,
   input  logic [2*NREQ-1:0]     wr_req,
   input  logic [LBA_W*NREQ-1:0] req_lba,
   input  logic [LEN_W*NREQ-1:0] req_length,
   input  logic [NREQ-1:0]       lock,
   output logic [NREQ-1:0]       busy,
   output logic [NREQ-1:0]       done,
   output logic [NREQ-1:0]       err,
   output logic [2*NREQ-1:0]     sd_rd,
   output logic [2*NREQ-1:0]     sd_wr,
   output logic [LBA_W-1:0]      sd_lba,
   output logic [LEN_W-1:0]      sd_length,
   input  logic                  sd_busy,
   input  logic                  sd_done,
   output logic [IDX_W-1:0]      owner,
   output logic                  active
);

   localparam logic [TO_W-1:0] CNT_MAX = '1;

   arb_state_t        state_q, state_d;
   logic [2*NREQ-1:0] sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
   logic [LBA_W-1:0]  sd_lba_q, sd_lba_d;
   logic [LEN_W-1:0]  sd_length_q, sd_length_d;
   logic [NREQ-1:0]   busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [IDX_W-1:0]  owner_q, owner_d, last_owner_q, last_owner_d;
   logic [TO_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic              active_q, active_d;
   logic              timeout;

   logic [NREQ-1:0]   pending;
   logic              pick_vld;
   logic [IDX_W-1:0]  pick_idx;
   logic [1:0]        pick_rd, pick_wr, pick_bits;
   logic [LBA_W-1:0]  pick_lba;
   logic [LEN_W-1:0]  pick_len;
   logic              pick_is_rd, pick_drive;
   logic [IDX_W:0]    pick_slot;

   // Any drive slot of either type counts as a pending request
   always_comb begin
      pending = '0;
      for (int r = 0; r < NREQ; r++) begin
         pending[r] = (|rd_req[2*r +: 2]) | (|wr_req[2*r +: 2]);
      end
   end

   sd_req_arbiter_rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .pending    (pending),
      .last_owner (last_owner_q),
      .lock       (lock),
      .pick_vld   (pick_vld),
      .pick_idx   (pick_idx)
   );

   // Mux out the picked requester's fields; reads beat writes, lowest drive slot wins
   always_comb begin
      pick_rd  = '0;
      pick_wr  = '0;
      pick_lba = '0;
      pick_len = '0;
      for (int r = 0; r < NREQ; r++) begin
         if (pick_idx == IDX_W'(r)) begin
            pick_rd  = rd_req[2*r +: 2];
            pick_wr  = wr_req[2*r +: 2];
            pick_lba = req_lba[LBA_W*r +: LBA_W];
            pick_len = req_length[LEN_W*r +: LEN_W];
         end
      end
      pick_is_rd = |pick_rd;
      pick_bits  = pick_is_rd ? pick_rd : pick_wr;
      pick_drive = ~pick_bits[0];
      pick_slot  = {pick_idx, pick_drive};
   end

   // Next-state: grant in IDLE, wait for accept in ISSUE, wait for finish in WAIT; handshakes beat the watchdog
   always_comb begin
      state_d      = state_q;
      sd_rd_d      = sd_rd_q;
      sd_wr_d      = sd_wr_q;
      sd_lba_d     = sd_lba_q;
      sd_length_d  = sd_length_q;
      busy_d       = '0;
      done_d       = '0;
      err_d        = '0;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      timeout      = (cnt_inc == CNT_MAX);
      cnt_d        = cnt_q;
      unique case (state_q)
         IDLE: begin
            sd_rd_d = '0;
            sd_wr_d = '0;
            cnt_d   = '0;
            if (pick_vld) begin
               sd_lba_d    = pick_lba;
               sd_length_d = pick_len;
               if (pick_is_rd) sd_rd_d[pick_slot] = 1'b1;
               else            sd_wr_d[pick_slot] = 1'b1;
               owner_d      = pick_idx;
               last_owner_d = pick_idx;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            if (sd_busy) begin
               sd_rd_d          = '0;
               sd_wr_d          = '0;
               busy_d[owner_q]  = 1'b1;
               cnt_d            = '0;
               if (sd_done) begin
                  done_d[owner_q] = 1'b1;
                  state_d         = IDLE;
               end else begin
                  state_d = WAIT;
               end
            end else if (timeout) begin
               sd_rd_d         = '0;
               sd_wr_d         = '0;
               err_d[owner_q]  = 1'b1;
               cnt_d           = cnt_inc;
               state_d         = IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         WAIT: begin
            if (sd_done) begin
               done_d[owner_q] = 1'b1;
               state_d         = IDLE;
            end else if (timeout) begin
               err_d[owner_q] = 1'b1;
               cnt_d          = cnt_inc;
               state_d        = IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            sd_rd_d = '0;
            sd_wr_d = '0;
            state_d = IDLE;
         end
      endcase
      active_d = (state_d != IDLE);
   end

   // State and registered outputs; reset drops any transfer silently
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         sd_rd_q      <= '0;
         sd_wr_q      <= '0;
         sd_lba_q     <= '0;
         sd_length_q  <= '0;
         busy_q       <= '0;
         done_q       <= '0;
         err_q        <= '0;
         owner_q      <= '0;
         last_owner_q <= IDX_W'(NREQ - 1);
         cnt_q        <= '0;
         active_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         sd_rd_q      <= sd_rd_d;
         sd_wr_q      <= sd_wr_d;
         sd_lba_q     <= sd_lba_d;
         sd_length_q  <= sd_length_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
         active_q     <= active_d;
      end
   end

   assign sd_rd     = sd_rd_q;
   assign sd_wr     = sd_wr_q;
   assign sd_lba    = sd_lba_q;
   assign sd_length = sd_length_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign owner     = owner_q;
   assign active    = active_q;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Bench for sd_req_arbiter: transaction-level reference model plus directed and random stimulus.
// Latency: model advances once per clock, outputs compared 1 ns after each rising edge.
// Backpressure: the bench plays both requesters and the SD controller.
module tb_sd_req_arbiter;

   localparam int NREQ  = 2;
   localparam int TO_W  = 4;
   localparam int LIMIT = (1 << TO_W) - 1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  rd_req, wr_req;
   logic [63:0] req_lba;
   logic [31:0] req_length;
   logic [1:0]  lock;
   logic [1:0]  busy, done, err;
   logic [3:0]  sd_rd, sd_wr;
   logic [31:0] sd_lba;
   logic [15:0] sd_length;
   logic        sd_busy, sd_done;
   logic        owner;
   logic        active;

   always #5 clk = ~clk;

   sd_req_arbiter #(.NREQ(NREQ), .TO_W(TO_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rd_req     (rd_req),
      .wr_req     (wr_req),
      .req_lba    (req_lba),
      .req_length (req_length),
      .lock       (lock),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .sd_rd      (sd_rd),
      .sd_wr      (sd_wr),
      .sd_lba     (sd_lba),
      .sd_length  (sd_length),
      .sd_busy    (sd_busy),
      .sd_done    (sd_done),
      .owner      (owner),
      .active     (active)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: one open transaction at most, described by who owns it and how far it got
   bit          m_open, m_acc, m_is_rd;
   int          m_owner, m_last, m_age, m_slot;
   logic [31:0] m_lba;
   logic [15:0] m_len;
   logic [1:0]  m_busy, m_done, m_err;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_open = 0; m_acc = 0; m_is_rd = 0;
      m_owner = 0; m_last = NREQ - 1; m_age = 0; m_slot = 0;
      m_lba = '0; m_len = '0;
      m_busy = '0; m_done = '0; m_err = '0;
   endtask

   task automatic model_step();
      logic [NREQ-1:0] pend;
      logic [1:0] rb, wb, bits;
      int pick;
      m_busy = '0; m_done = '0; m_err = '0;
      if (!m_open) begin
         for (int r = 0; r < NREQ; r++)
            pend[r] = (rd_req[2*r +: 2] != 2'b00) || (wr_req[2*r +: 2] != 2'b00);
         pick = -1;
         if (lock[m_last] && pend[m_last]) pick = m_last;
         else
            for (int k = 1; k <= NREQ; k++)
               if (pick < 0 && pend[(m_last + k) % NREQ]) pick = (m_last + k) % NREQ;
         if (pick >= 0) begin
            rb = rd_req[2*pick +: 2];
            wb = wr_req[2*pick +: 2];
            m_is_rd = (rb != 2'b00);
            bits = m_is_rd ? rb : wb;
            m_slot = 2*pick + (bits[0] ? 0 : 1);
            m_lba = req_lba[32*pick +: 32];
            m_len = req_length[16*pick +: 16];
            m_owner = pick; m_last = pick;
            m_open = 1; m_acc = 0; m_age = 0;
         end
      end else begin
         m_age++;
         if (!m_acc && sd_busy) begin
            m_busy[m_owner] = 1'b1;
            if (sd_done) begin
               m_done[m_owner] = 1'b1;
               m_open = 0;
            end else begin
               m_acc = 1; m_age = 0;
            end
         end else if (m_acc && sd_done) begin
            m_done[m_owner] = 1'b1;
            m_open = 0;
         end else if (m_age >= LIMIT) begin
            m_err[m_owner] = 1'b1;
            m_open = 0;
         end
      end
   endtask

   // Advance one clock and compare every DUT output with the model
   task automatic tick();
      logic [3:0] er, ew;
      if (!reset_n) model_reset(); else model_step();
      @(posedge clk);
      #1;
      er = '0; ew = '0;
      if (m_open && !m_acc) begin
         if (m_is_rd) er[m_slot] = 1'b1; else ew[m_slot] = 1'b1;
      end
      chk("sd_rd", sd_rd, er);
      chk("sd_wr", sd_wr, ew);
      chk("sd_lba", sd_lba, m_lba);
      chk("sd_length", sd_length, m_len);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("owner", owner, m_owner);
      chk("active", active, m_open);
      chk("onehot_sd", $countones(sd_rd | sd_wr) <= 1, 1'b1);
   endtask

   // Wait for a grant, then accept and finish it; reports the owner and request vectors seen
   task automatic serve(output int who, output logic [3:0] rdv, output logic [3:0] wrv);
      int n;
      n = 0; who = -1; rdv = '0; wrv = '0;
      while (sd_rd == 4'b0 && sd_wr == 4'b0 && n < 10) begin
         tick();
         n++;
      end
      if (sd_rd == 4'b0 && sd_wr == 4'b0) begin
         n_checks++;
         n_errors++;
         $display("FAIL serve_grant: no grant within %0d cycles", n);
         return;
      end
      who = owner; rdv = sd_rd; wrv = sd_wr;
      sd_busy = 1'b1; tick(); sd_busy = 1'b0;
      sd_done = 1'b1; tick(); sd_done = 1'b0;
   endtask

   int          who, n, rs_cnt;
   logic [3:0]  rv, wv;
   int          exp_rr [4] = '{0, 1, 0, 1};
   int          exp_lk [4] = '{1, 1, 1, 0};

   initial begin
      reset_n = 1'b1;
      rd_req = '0; wr_req = '0; req_lba = '0; req_length = '0; lock = '0;
      sd_busy = 1'b0; sd_done = 1'b0;
      model_reset();
      #1 reset_n = 1'b0;
      #2;
      chk("rst_sd_rd", sd_rd, 4'b0);
      chk("rst_sd_wr", sd_wr, 4'b0);
      chk("rst_busy_done_err", {busy, done, err}, 6'b0);
      chk("rst_sd_lba", sd_lba, 32'h0);
      chk("rst_sd_length", sd_length, 16'h0);
      chk("rst_owner_active", {owner, active}, 2'b00);
      #9 reset_n = 1'b1;

      // Single ACSI read
      rd_req = 4'b0100;
      req_lba[63:32] = 32'h1234;
      req_length[31:16] = 16'd3;
      tick();
      chk("single_sd_rd", sd_rd, 4'b0100);
      chk("single_sd_lba", sd_lba, 32'h1234);
      chk("single_sd_length", sd_length, 16'd3);
      rd_req = '0;
      sd_busy = 1'b1; tick(); sd_busy = 1'b0;
      chk("single_busy", {busy, sd_rd}, 6'b10_0000);
      sd_done = 1'b1; tick(); sd_done = 1'b0;
      chk("single_done", {done, active}, 3'b10_0);

      // Round robin with both requesters pending
      rd_req = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         serve(who, rv, wv);
         chk($sformatf("rr_owner%0d", i), who, exp_rr[i]);
      end

      // Lock keeps ACSI three times, then floppy gets it
      lock = 2'b10;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) lock = 2'b00;
         serve(who, rv, wv);
         chk($sformatf("lock_owner%0d", i), who, exp_lk[i]);
      end
      rd_req = '0;

      // Read beats write from the same requester; write follows
      rd_req = 4'b0010; wr_req = 4'b0001;
      serve(who, rv, wv);
      chk("conflict_rd_first", {rv, wv}, 8'b0010_0000);
      rd_req = '0;
      serve(who, rv, wv);
      chk("conflict_wr_next", {rv, wv}, 8'b0000_0001);
      wr_req = '0;

      // Watchdog with no SD response
      rd_req = 4'b0001;
      tick();
      chk("to_grant", sd_rd, 4'b0001);
      n = 0;
      while (err == 2'b00 && n < 40) begin
         tick();
         n++;
      end
      rd_req = '0;
      chk("to_cycles", n, 15);
      chk("to_err", {err, sd_rd}, 6'b01_0000);

      // Accept and finish in one cycle
      rd_req = 4'b0100;
      tick(); rd_req = '0;
      tick(); tick();
      sd_busy = 1'b1; sd_done = 1'b1; tick(); sd_busy = 1'b0; sd_done = 1'b0;
      chk("bd_same_cycle", {busy, done, err, active}, 7'b10_10_00_0);

      // Handshakes arriving exactly on the watchdog limit win; request dropped before accept
      rd_req = 4'b0001;
      tick(); rd_req = '0;
      repeat (14) tick();
      sd_busy = 1'b1; tick(); sd_busy = 1'b0;
      chk("edge_busy", {busy, err}, 4'b01_00);
      repeat (14) tick();
      sd_done = 1'b1; tick(); sd_done = 1'b0;
      chk("edge_done", {done, err}, 4'b01_00);

      // Asynchronous reset while in WAIT
      rd_req = 4'b0100;
      tick();
      sd_busy = 1'b1; tick(); sd_busy = 1'b0; rd_req = '0;
      #2 reset_n = 1'b0;
      #1;
      chk("arst_outputs", {busy, done, err, sd_rd, sd_wr, owner, active}, 16'h0);
      chk("arst_lba_len", {sd_lba, sd_length}, 48'h0);
      model_reset();
      tick();
      reset_n = 1'b1;
      sd_done = 1'b1; tick(); sd_done = 1'b0;
      chk("arst_no_done", {done, active}, 3'b0);

      // Random traffic
      rs_cnt = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int r = 0; r < NREQ; r++) begin
            if ((rd_req[2*r +: 2] | wr_req[2*r +: 2]) != 2'b00) begin
               if ((m_busy[r] || m_err[r]) && ($urandom % 4 != 0)) begin
                  rd_req[2*r +: 2] = 2'b00;
                  wr_req[2*r +: 2] = 2'b00;
               end else if ($urandom % 40 == 0) begin
                  rd_req[2*r +: 2] = 2'b00;
                  wr_req[2*r +: 2] = 2'b00;
               end
            end else if ($urandom % 4 == 0) begin
               rd_req[2*r +: 2] = 2'($urandom);
               wr_req[2*r +: 2] = 2'($urandom);
               if (rd_req[2*r +: 2] == 2'b00 && wr_req[2*r +: 2] == 2'b00) rd_req[2*r] = 1'b1;
               req_lba[32*r +: 32] = $urandom;
               req_length[16*r +: 16] = 16'($urandom);
            end
         end
         if ($urandom % 8 == 0) lock = 2'($urandom);
         sd_busy = 1'b0; sd_done = 1'b0;
         if (!m_open) begin
            rs_cnt = $urandom % 18;
         end else if (rs_cnt == 0) begin
            if (!m_acc) begin
               sd_busy = 1'b1;
               if ($urandom % 6 == 0) sd_done = 1'b1;
            end else begin
               sd_done = 1'b1;
            end
            rs_cnt = $urandom % 18;
         end else begin
            rs_cnt--;
         end
         if ($urandom % 30 == 0) sd_done = 1'b1;
         if ($urandom % 30 == 0) sd_busy = 1'b1;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
